// File: rtl/bus_responder.sv
// Target-side responder for the 8088 minimum-mode bus: decodes ALE/strobe cycles,
// forwards them to a one-request backend port and answers the two-pulse INTA sequence.
module bus_responder #(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [7:0]  IDLE_DATA   = 8'hFF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ALE,
  input  logic        INTA_n,
  input  logic        RD_n,
  input  logic        WR_n,
  input  logic        IOM,
  input  logic        DTR,
  input  logic        DEN_n,
  input  logic [7:0]  outAD,
  input  logic [7:0]  enAD,
  input  logic [11:0] A,
  output logic [7:0]  inAD,
  output logic        READY,
  output logic        be_req,
  output logic [19:0] be_addr,
  output logic        be_io,
  output logic        be_we,
  output logic [7:0]  be_wdata,
  input  logic        be_ack,
  input  logic [7:0]  be_rdata,
  input  logic [7:0]  int_vector,
  output logic        int_ack,
  output logic        proto_err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    RD_REQ  = 3'd2,
    WR_REQ  = 3'd3,
    WAITCNT = 3'd4,
    HOLD    = 3'd5,
    INTA    = 3'd6
  } state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t      state_q, state_d;
  logic        inta_phase_q, inta_phase_d;
  logic        inta_first_q, inta_first_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        ready_d, be_req_d, be_we_d, be_io_d, int_ack_d, proto_err_d;
  logic [7:0]  inad_d, be_wdata_d;
  logic [19:0] be_addr_d;
  logic [1:0]  n_strobe;

  assign n_strobe  = 2'(!RD_n) + 2'(!WR_n) + 2'(!INTA_n);
  assign dbg_state = state_q;

  // Backend handshake: be_req rises with a stable be_addr/be_io/be_we/be_wdata and
  // stays high until the first edge that samples be_ack=1 (ack may arrive in the
  // same cycle be_req rises); be_rdata is only taken on that edge.
  always_comb begin
    state_d      = state_q;
    inta_phase_d = inta_phase_q;
    inta_first_d = inta_first_q;
    wait_cnt_d   = wait_cnt_q;
    data_d       = data_q;
    ready_d      = READY;
    inad_d       = IDLE_DATA;
    be_req_d     = be_req;
    be_we_d      = be_we;
    be_addr_d    = be_addr;
    be_io_d      = be_io;
    be_wdata_d   = be_wdata;
    int_ack_d    = 1'b0;
    proto_err_d  = 1'b0;

    if (ALE) begin
      be_addr_d = {A, outAD};
      be_io_d   = IOM;
      state_d   = ADDR;
      // A new address phase in the middle of an operation abandons it.
      if (state_q != IDLE && state_q != ADDR) begin
        proto_err_d = 1'b1;
        be_req_d    = 1'b0;
        ready_d     = 1'b1;
        wait_cnt_d  = 4'd0;
      end
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (n_strobe > 2'd1) begin
            proto_err_d = 1'b1;
            state_d     = IDLE;
          end else if (!RD_n) begin
            be_req_d     = 1'b1;
            be_we_d      = 1'b0;
            ready_d      = 1'b0;
            state_d      = RD_REQ;
            proto_err_d  = DTR | inta_phase_q;
            inta_phase_d = 1'b0;
          end else if (!WR_n) begin
            if (enAD == 8'hFF) begin
              be_wdata_d   = outAD;
              be_req_d     = 1'b1;
              be_we_d      = 1'b1;
              ready_d      = 1'b0;
              state_d      = WR_REQ;
              proto_err_d  = !DTR | inta_phase_q;
              inta_phase_d = 1'b0;
            end
          end else if (!INTA_n) begin
            state_d      = INTA;
            inta_first_d = 1'b1;
          end
        end
        RD_REQ, WR_REQ: begin
          if (be_ack) begin
            be_req_d = 1'b0;
            if (state_q == RD_REQ) data_d = be_rdata;
            if (WS == 4'd0) begin
              ready_d = 1'b1;
              state_d = HOLD;
            end else begin
              wait_cnt_d = WS;
              state_d    = WAITCNT;
            end
          end
        end
        WAITCNT: begin
          if (wait_cnt_q <= 4'd1) begin
            wait_cnt_d = 4'd0;
            ready_d    = 1'b1;
            state_d    = HOLD;
          end else begin
            wait_cnt_d = wait_cnt_q - 4'd1;
          end
        end
        HOLD: begin
          if (!RD_n && !DEN_n) inad_d = data_q;
          if (be_we ? WR_n : RD_n) state_d = IDLE;
        end
        INTA: begin
          inta_first_d = 1'b0;
          if (inta_phase_q) begin
            int_ack_d = inta_first_q;
            if (!INTA_n && !DEN_n) inad_d = int_vector;
          end
          if (INTA_n) begin
            inta_phase_d = !inta_phase_q;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      inta_phase_q <= 1'b0;
      inta_first_q <= 1'b0;
      wait_cnt_q   <= 4'd0;
      data_q       <= 8'h00;
      READY        <= 1'b1;
      inAD         <= IDLE_DATA;
      be_req       <= 1'b0;
      be_we        <= 1'b0;
      be_addr      <= 20'h0;
      be_io        <= 1'b0;
      be_wdata     <= 8'h00;
      int_ack      <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      inta_phase_q <= inta_phase_d;
      inta_first_q <= inta_first_d;
      wait_cnt_q   <= wait_cnt_d;
      data_q       <= data_d;
      READY        <= ready_d;
      inAD         <= inad_d;
      be_req       <= be_req_d;
      be_we        <= be_we_d;
      be_addr      <= be_addr_d;
      be_io        <= be_io_d;
      be_wdata     <= be_wdata_d;
      int_ack      <= int_ack_d;
      proto_err    <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: two instances (WAIT_STATES 0 and 2) share one CPU bus model,
// sel picks which one sees the bus; a negedge monitor checks observed events against exp_q.
module tb_bus_responder;

  localparam logic [3:0] EV_REQ  = 4'd1;
  localparam logic [3:0] EV_RDY  = 4'd2;
  localparam logic [3:0] EV_INAD = 4'd3;
  localparam logic [3:0] EV_ACK  = 4'd4;
  localparam logic [3:0] EV_ERR  = 4'd5;

  // clock / reset
  logic CLK, RESET;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        ALE, INTA_n, RD_n, WR_n, IOM, DTR, DEN_n, be_ack, sel;
  logic [7:0]  outAD, enAD, be_rdata, int_vector;
  logic [11:0] A;

  logic [7:0]  inad0, inad1, wdata0, wdata1;
  logic [19:0] addr0, addr1;
  logic        ready0, ready1, req0, req1, io0, io1, we0, we1;
  logic        iack0, iack1, perr0, perr1;
  logic [2:0]  dbg0, dbg1;

  bus_responder #(.WAIT_STATES(0), .IDLE_DATA(8'hFF)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .ALE(ALE & ~sel), .INTA_n(INTA_n | sel),
    .RD_n(RD_n | sel), .WR_n(WR_n | sel), .IOM(IOM), .DTR(DTR), .DEN_n(DEN_n | sel),
    .outAD(outAD), .enAD(enAD), .A(A), .inAD(inad0), .READY(ready0),
    .be_req(req0), .be_addr(addr0), .be_io(io0), .be_we(we0), .be_wdata(wdata0),
    .be_ack(be_ack & ~sel), .be_rdata(be_rdata), .int_vector(int_vector),
    .int_ack(iack0), .proto_err(perr0), .dbg_state(dbg0)
  );

  bus_responder #(.WAIT_STATES(2), .IDLE_DATA(8'hFF)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .ALE(ALE & sel), .INTA_n(INTA_n | ~sel),
    .RD_n(RD_n | ~sel), .WR_n(WR_n | ~sel), .IOM(IOM), .DTR(DTR), .DEN_n(DEN_n | ~sel),
    .outAD(outAD), .enAD(enAD), .A(A), .inAD(inad1), .READY(ready1),
    .be_req(req1), .be_addr(addr1), .be_io(io1), .be_we(we1), .be_wdata(wdata1),
    .be_ack(be_ack & sel), .be_rdata(be_rdata), .int_vector(int_vector),
    .int_ack(iack1), .proto_err(perr1), .dbg_state(dbg1)
  );

  logic        m_ready, m_req, m_io, m_we, m_iack, m_perr;
  logic [7:0]  m_inad, m_wdata;
  logic [19:0] m_addr;
  assign m_ready = sel ? ready1 : ready0;
  assign m_req   = sel ? req1   : req0;
  assign m_io    = sel ? io1    : io0;
  assign m_we    = sel ? we1    : we0;
  assign m_iack  = sel ? iack1  : iack0;
  assign m_perr  = sel ? perr1  : perr0;
  assign m_inad  = sel ? inad1  : inad0;
  assign m_wdata = sel ? wdata1 : wdata0;
  assign m_addr  = sel ? addr1  : addr0;

  // scoreboard
  logic [33:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] kind, input logic [29:0] val);
    exp_q.push_back({kind, val});
  endtask

  function automatic string ev_name(input logic [3:0] kind);
    case (kind)
      EV_REQ:  return "be_req_issue";
      EV_RDY:  return "ready_low_cycles";
      EV_INAD: return "inad_value";
      EV_ACK:  return "int_ack_pulse";
      EV_ERR:  return "proto_err_pulse";
      default: return "event";
    endcase
  endfunction

  task automatic ev(input logic [3:0] kind, input logic [29:0] val);
    logic [33:0] act;
    logic [33:0] exp;
    act = {kind, val};
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_%s: got %h expected none", ev_name(kind), act);
    end else begin
      exp = exp_q.pop_front();
      check(ev_name(exp[33:30]), act, exp);
    end
  endtask

  // monitor
  logic       prev_ready = 1'b1;
  logic       prev_req   = 1'b0;
  logic [7:0] prev_inad  = 8'hFF;
  int         low_cnt    = 0;

  always @(negedge CLK) begin
    if (m_perr) ev(EV_ERR, 30'd0);
    if (m_iack) ev(EV_ACK, 30'd0);
    if (m_req && !prev_req) ev(EV_REQ, {m_we, m_io, (m_we ? m_wdata : 8'h00), m_addr});
    if (m_ready && !prev_ready) begin
      ev(EV_RDY, 30'(low_cnt));
      low_cnt = 0;
    end
    if (!m_ready) low_cnt++;
    if (m_inad != prev_inad) ev(EV_INAD, {22'd0, m_inad});
    prev_ready = m_ready;
    prev_req   = m_req;
    prev_inad  = m_inad;
  end

  // backend model: acks bk_dly cycles after be_req is first seen
  int bk_dly = 0;
  int age    = 0;
  initial begin
    be_ack = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (m_req) begin
        be_ack = (age == bk_dly);
        age++;
      end else begin
        be_ack = 1'b0;
        age    = 0;
      end
    end
  end

  // driver tasks
  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_bus();
    ALE = 1'b0; RD_n = 1'b1; WR_n = 1'b1; INTA_n = 1'b1; DEN_n = 1'b1;
    DTR = 1'b0; enAD = 8'h00;
  endtask

  task automatic addr_phase(input logic [19:0] addr, input logic io, input logic dtr);
    ALE = 1'b1; A = addr[19:8]; outAD = addr[7:0]; enAD = 8'hFF; IOM = io; DTR = dtr;
    next();
    ALE = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!m_ready && n < 64) begin
      next();
      n++;
    end
    check("ready_return", {33'd0, m_ready}, 34'd1);
  endtask

  task automatic bus_read(input logic [19:0] addr, input logic io, input int dly,
                          input logic [7:0] rdata, input int exp_low, input logic do_ale);
    push(EV_REQ, {1'b0, io, 8'h00, addr});
    push(EV_RDY, 30'(exp_low));
    push(EV_INAD, {22'd0, rdata});
    push(EV_INAD, {22'd0, 8'hFF});
    bk_dly = dly; be_rdata = rdata;
    if (do_ale) addr_phase(addr, io, 1'b0);
    RD_n = 1'b0; DEN_n = 1'b0; enAD = 8'h00;
    next();
    wait_ready();
    next();
    next();
    RD_n = 1'b1; DEN_n = 1'b1;
    next();
    next();
  endtask

  task automatic bus_write(input logic [19:0] addr, input logic io, input logic [7:0] data,
                           input int dly, input int exp_low);
    push(EV_REQ, {1'b1, io, data, addr});
    push(EV_RDY, 30'(exp_low));
    bk_dly = dly;
    addr_phase(addr, io, 1'b1);
    WR_n = 1'b0; DEN_n = 1'b0; outAD = data; enAD = 8'hFF;
    next();
    wait_ready();
    next();
    WR_n = 1'b1; DEN_n = 1'b1; DTR = 1'b0;
    next();
    next();
  endtask

  task automatic inta_pulse(input logic expect_vec, input logic [7:0] vec);
    if (expect_vec) begin
      push(EV_ACK, 30'd0);
      push(EV_INAD, {22'd0, vec});
      push(EV_INAD, {22'd0, 8'hFF});
    end
    int_vector = vec;
    addr_phase(20'h00000, 1'b0, 1'b0);
    enAD = 8'h00; INTA_n = 1'b0; DEN_n = 1'b0;
    next();
    next();
    next();
    INTA_n = 1'b1; DEN_n = 1'b1;
    next();
    next();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; sel = 1'b0; A = 12'h0; outAD = 8'h0; IOM = 1'b0;
    be_rdata = 8'h00; int_vector = 8'h00;
    idle_bus();
    next();
    next();
    @(negedge CLK);
    check("rst_ready",     {33'd0, ready0}, 34'd1);
    check("rst_inad",      {26'd0, inad0},  34'hFF);
    check("rst_be_req",    {33'd0, req0},   34'd0);
    check("rst_be_we",     {33'd0, we0},    34'd0);
    check("rst_be_addr",   {14'd0, addr0},  34'd0);
    check("rst_be_io",     {33'd0, io0},    34'd0);
    check("rst_be_wdata",  {26'd0, wdata0}, 34'd0);
    check("rst_int_ack",   {33'd0, iack0},  34'd0);
    check("rst_proto_err", {33'd0, perr0},  34'd0);
    check("rst_state",     {31'd0, dbg0},   34'd0);
    check("rst_ready_ws2", {33'd0, ready1}, 34'd1);
    next();
    RESET = 1'b0;
    next();

    // memory read, ack 3 cycles after request, no wait states
    bus_read(20'h12345, 1'b0, 3, 8'hA5, 4, 1'b1);

    // IO write, same-cycle ack, two wait states
    sel = 1'b1;
    next();
    bus_write(20'h00060, 1'b1, 8'h3C, 0, 3);
    sel = 1'b0;
    next();

    // two-pulse interrupt acknowledge
    inta_pulse(1'b0, 8'h08);
    inta_pulse(1'b1, 8'h08);

    // reset while the read request is outstanding
    push(EV_REQ, {1'b0, 1'b0, 8'h00, 20'h24680});
    push(EV_RDY, 30'd1);
    bk_dly = 1000;
    addr_phase(20'h24680, 1'b0, 1'b0);
    RD_n = 1'b0; DEN_n = 1'b0; enAD = 8'h00;
    next();
    @(posedge CLK);
    #3 RESET = 1'b1;
    @(negedge CLK);
    check("abort_ready",  {33'd0, m_ready}, 34'd1);
    check("abort_be_req", {33'd0, m_req},   34'd0);
    check("abort_inad",   {26'd0, m_inad},  34'hFF);
    idle_bus();
    next();
    RESET = 1'b0;
    next();
    bus_read(20'hFFFF0, 1'b0, 1, 8'h5A, 2, 1'b1);

    // RD_n and WR_n low together in the address phase
    push(EV_ERR, 30'd0);
    addr_phase(20'h00200, 1'b0, 1'b0);
    RD_n = 1'b0; WR_n = 1'b0; DEN_n = 1'b0;
    next();
    idle_bus();
    next();
    next();

    // ALE during the wait-state countdown, then a read at the newly latched address
    sel = 1'b1;
    next();
    push(EV_REQ, {1'b1, 1'b0, 8'hC3, 20'h0BEEF});
    push(EV_ERR, 30'd0);
    push(EV_RDY, 30'd2);
    bk_dly = 0;
    addr_phase(20'h0BEEF, 1'b0, 1'b1);
    WR_n = 1'b0; DEN_n = 1'b0; outAD = 8'hC3; enAD = 8'hFF;
    next();
    next();
    idle_bus();
    ALE = 1'b1; A = 12'hABC; outAD = 8'hDE; IOM = 1'b0; enAD = 8'hFF;
    next();
    ALE = 1'b0;
    bus_read(20'hABCDE, 1'b0, 0, 8'h77, 3, 1'b0);
    sel = 1'b0;
    next();

    // a read between INTA pulses cancels the sequence
    inta_pulse(1'b0, 8'h08);
    push(EV_ERR, 30'd0);
    bus_read(20'h00100, 1'b1, 0, 8'h11, 1, 1'b1);
    inta_pulse(1'b0, 8'h08);

    repeat (4) next();
    check("queue_drained", 34'(exp_q.size()), 34'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Target-side responder for the 8088 minimum-mode bus that the core's bus interface initiates on.
- Decodes ALE/RD_n/WR_n/INTA_n/IOM bus cycles and latches the 20-bit address.
- Issues one request per cycle on a simple backend memory/IO port, returns read data on inAD, and throttles the CPU with READY.
- Serves the two-pulse INTA sequence by supplying an interrupt vector. Sits beside the core in the bench and in the FPGA top.

Parameters:
- WAIT_STATES, 0: extra CLK cycles READY is held low after backend ack (0..15).
- IDLE_DATA, 8'hFF: value on inAD when the responder is not driving (pull-up emulation).

Ports:
- CLK  in  1  core bus clock; all state on rising edge
- RESET  in  1  asynchronous, active-high reset
- ALE  in  1  address latch enable from CPU
- INTA_n  in  1  interrupt acknowledge strobe
- RD_n  in  1  read strobe
- WR_n  in  1  write strobe
- IOM  in  1  1=IO cycle, 0=memory cycle
- DTR  in  1  1=CPU transmit (write), 0=receive
- DEN_n  in  1  data enable
- outAD  in  8  CPU-driven AD7:0
- enAD  in  8  per-bit CPU drive enables on AD7:0
- A  in  12  CPU address A19:8
- inAD  out  8  data returned to CPU
- READY  out  1  CPU wait control
- be_req  out  1  backend request, held until be_ack
- be_addr  out  20  latched address
- be_io  out  1  latched IOM
- be_we  out  1  1=write
- be_wdata  out  8  write data
- be_ack  in  1  backend completion (same-cycle ack legal)
- be_rdata  in  8  read data, valid with be_ack
- int_vector  in  8  vector returned on 2nd INTA
- int_ack  out  1  one-cycle pulse when vector is delivered
- proto_err  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset values: state=IDLE, READY=1, inAD=IDLE_DATA, be_req=0, be_we=0, be_addr=0, be_io=0, be_wdata=0, int_ack=0, proto_err=0, inta_phase=0, wait counter=0.
- RESET asserted mid-cycle aborts immediately; the backend must drop any outstanding request when be_req falls.
- States: IDLE, ADDR, RD_REQ, WR_REQ, WAITCNT, HOLD, INTA.
- IDLE or any state, ALE=1 at edge:
  - latch be_addr={A,outAD} and be_io=IOM; go to ADDR.
  - ALE seen in any state other than IDLE/ADDR: proto_err pulse; current op abandoned; be_req=0, READY=1.
- ADDR, first edge with ALE=0 and a strobe low:
  - RD_n=0: be_req=1, be_we=0, READY=0, go to RD_REQ. DTR=1 here gives a proto_err pulse, but the cycle proceeds.
  - WR_n=0 and enAD=8'hFF: be_wdata=outAD, be_req=1, be_we=1, READY=0, go to WR_REQ. DTR=0 gives a proto_err pulse. WR_n=0 with enAD not all ones: stay in ADDR.
  - INTA_n=0: go to INTA.
  - More than one strobe low: proto_err pulse, return to IDLE.
- RD_REQ/WR_REQ, on be_ack=1:
  - be_req=0; on a read, capture be_rdata into the data register.
  - WAIT_STATES=0: READY=1 next edge, go to HOLD.
  - Otherwise go to WAITCNT with counter=WAIT_STATES.
- WAITCNT: decrement each edge; at 1, READY=1 and go to HOLD. Total READY-low time is (cycles to ack)+WAIT_STATES+1.
- HOLD:
  - inAD=data register while RD_n=0 and DEN_n=0, else IDLE_DATA.
  - Strobe rising returns to IDLE.
- INTA:
  - inta_phase=0: no data driven, READY stays 1. On INTA_n rising, inta_phase=1 and go to IDLE.
  - inta_phase=1: drive inAD=int_vector while INTA_n=0 and DEN_n=0. int_ack pulses on the first INTA-state edge. On INTA_n rising, inta_phase=0 and go to IDLE.
  - A non-INTA cycle between the two pulses clears inta_phase and raises proto_err.
- inAD is registered; it changes one edge after the qualifying condition.
- Address, io and write data are stable from latch until the next ALE.

Test Plan:
- Reset, then mem read 0x12345 with be_ack 3 cycles after be_req and WAIT_STATES=0, be_rdata=0xA5:
  - be_addr=0x12345, be_io=0, READY low for 4 cycles.
  - inAD=0xA5 while RD_n low, then 0xFF.
- IO write to 0x00060, data 0x3C, same-cycle ack, WAIT_STATES=2 -> be_we=1, be_wdata=0x3C, be_io=1, READY low for exactly 3 cycles.
- Two INTA pulses with int_vector=0x08:
  - 1st pulse: inAD=0xFF, no int_ack.
  - 2nd pulse: inAD=0x08, int_ack one cycle.
- RESET asserted while in RD_REQ -> next sample shows READY=1, be_req=0, inAD=0xFF; a subsequent read at 0xFFFF0 completes normally.
- Violations:
  - RD_n and WR_n both low in ADDR -> proto_err pulse, no be_req.
  - ALE during WAITCNT -> proto_err pulse and new address latched.
